// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages.
//   XLEN        : default datapath width
//   ALU_*       : ALU operation codes carried on id_ex_alu_ctrl
//   FWD_*       : forwarding mux selects (11 is treated as FWD_IDEX)
//   ex_state_e  : execute-stage sequencing states for the multi-cycle MUL
//   is_mul_op() : true when the ALU code requests the sequential multiplier
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } ex_state_e;

    function automatic logic is_mul_op(input logic [3:0] alu_ctrl);
        return (alu_ctrl == ALU_MUL);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one iteration per clock.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-low reset
//   i_start            : latch operands, clear product/counter, begin iterating
//   i_abort            : stop immediately (has priority over i_start)
//   i_multiplicand     : operand shifted left each iteration
//   i_multiplier       : operand whose LSB gates each accumulation
//   o_busy             : iterations in progress
//   o_done             : the current cycle performs the final iteration
//   o_product          : low XLEN bits of the unsigned product
module seq_multiplier #(
    parameter int XLEN       = pipeline_pkg::XLEN,
    parameter int MUL_CYCLES = pipeline_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_multiplicand,
    input  logic [XLEN-1:0] i_multiplier,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);
    import pipeline_pkg::*;

    localparam int            CW   = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_product;
    logic [CW-1:0]   r_count;
    logic            r_busy;

    // Shift-add datapath and iteration counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (i_abort) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_mcand   <= i_multiplicand;
            r_mplier  <= i_multiplier;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_product <= r_product + r_mcand;
            end else begin
                r_product <= r_product;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (r_count == LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_count == LAST);
    assign o_product = r_product;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch-equality flag, multi-cycle
// MUL sequencing and the EX/MEM pipeline register.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-low reset
//   id_ex_*                      : operands and controls from the ID/EX register
//   forward_a/b, alu_ex_mem,
//   wb_data                      : forwarding selects and forwarded values
//   flush                        : squash the instruction currently in EX
//   stall_out                    : hold IF/ID and ID/EX (combinational)
//   *_out                        : EX/MEM register outputs to the MEM stage
module ex_stage #(
    parameter int XLEN       = pipeline_pkg::XLEN,
    parameter int MUL_CYCLES = pipeline_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_ex_mem_to_reg,
    input  logic            id_ex_reg_write,
    input  logic            id_ex_mem_read,
    input  logic            id_ex_mem_write,
    input  logic            id_ex_beq,
    input  logic [3:0]      id_ex_alu_ctrl,
    input  logic            id_ex_alu_src,
    input  logic [XLEN-1:0] id_ex_rs1_data,
    input  logic [XLEN-1:0] id_ex_rs2_data,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_reg_rd,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] alu_ex_mem,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall_out,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            beq_instruction_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] mux2_result_out,
    output logic            flag_beq_out,
    output logic [4:0]      reg_rd_out
);
    import pipeline_pkg::*;

    ex_state_e       r_state;
    ex_state_e       w_state_next;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_opb;
    logic [XLEN-1:0] w_alu;
    logic            w_is_mul;
    logic            w_mul_start;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_product;
    logic            w_bubble;

    // Operands captured at MUL start so DONE ignores the forwarding paths.
    logic [XLEN-1:0] r_hold_a;
    logic [XLEN-1:0] r_hold_b;

    logic            r_mem_to_reg;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_beq;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_mux2_result;
    logic            r_flag_beq;
    logic [4:0]      r_reg_rd;

    // Forwarding selection for both operands; select 11 falls back to ID/EX.
    always_comb begin
        w_fwd_a = id_ex_rs1_data;
        w_fwd_b = id_ex_rs2_data;
        case (forward_a)
            FWD_IDEX:  w_fwd_a = id_ex_rs1_data;
            FWD_EXMEM: w_fwd_a = alu_ex_mem;
            FWD_WB:    w_fwd_a = wb_data;
            default:   w_fwd_a = id_ex_rs1_data;
        endcase
        case (forward_b)
            FWD_IDEX:  w_fwd_b = id_ex_rs2_data;
            FWD_EXMEM: w_fwd_b = alu_ex_mem;
            FWD_WB:    w_fwd_b = wb_data;
            default:   w_fwd_b = id_ex_rs2_data;
        endcase
    end

    assign w_opb    = id_ex_alu_src ? id_ex_imm : w_fwd_b;
    assign w_is_mul = is_mul_op(id_ex_alu_ctrl);

    // Single-cycle ALU; MUL is produced by the sequential multiplier instead.
    always_comb begin
        w_alu = '0;
        case (id_ex_alu_ctrl)
            ALU_ADD: w_alu = w_fwd_a + w_opb;
            ALU_SUB: w_alu = w_fwd_a - w_opb;
            ALU_AND: w_alu = w_fwd_a & w_opb;
            ALU_OR:  w_alu = w_fwd_a | w_opb;
            ALU_XOR: w_alu = w_fwd_a ^ w_opb;
            ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_opb))};
            ALU_SLL: w_alu = w_fwd_a << w_opb[4:0];
            ALU_SRL: w_alu = w_fwd_a >> w_opb[4:0];
            ALU_MUL: w_alu = '0;
            default: w_alu = '0;
        endcase
    end

    // Only an IDLE-state MUL starts the multiplier, so the held opcode in DONE
    // cannot retrigger it.
    assign w_mul_start = (r_state == ST_IDLE) && w_is_mul && !flush;

    seq_multiplier #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock          (clock),
        .reset          (reset),
        .i_start        (w_mul_start),
        .i_abort        (flush),
        .i_multiplicand (w_fwd_a),
        .i_multiplier   (w_opb),
        .o_busy         (w_mul_busy),
        .o_done         (w_mul_done),
        .o_product      (w_product)
    );

    // FSM next-state; flush overrides every transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mul_start) begin
                    w_state_next = ST_MUL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                end else if (!w_mul_busy) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            w_state_next = w_state_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture forwarded operands for the MUL writeback in DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hold_a <= '0;
            r_hold_b <= '0;
        end else if (w_mul_start) begin
            r_hold_a <= w_fwd_a;
            r_hold_b <= w_fwd_b;
        end else begin
            r_hold_a <= r_hold_a;
            r_hold_b <= r_hold_b;
        end
    end

    // Stall covers the launch cycle and every iteration; DONE releases it.
    assign stall_out = reset && (w_mul_start || (r_state == ST_MUL));
    assign w_bubble  = flush || w_mul_start || (r_state == ST_MUL);

    // EX/MEM pipeline register.
    always_ff @(posedge clock) begin
        if (!reset || w_bubble) begin
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_beq         <= 1'b0;
            r_alu_result  <= '0;
            r_mux2_result <= '0;
            r_flag_beq    <= 1'b0;
            r_reg_rd      <= 5'd0;
        end else if (r_state == ST_DONE) begin
            r_mem_to_reg  <= id_ex_mem_to_reg;
            r_reg_write   <= id_ex_reg_write;
            r_mem_read    <= id_ex_mem_read;
            r_mem_write   <= id_ex_mem_write;
            r_beq         <= id_ex_beq;
            r_alu_result  <= w_product;
            r_mux2_result <= r_hold_b;
            r_flag_beq    <= (r_hold_a == r_hold_b);
            r_reg_rd      <= id_ex_reg_rd;
        end else begin
            r_mem_to_reg  <= id_ex_mem_to_reg;
            r_reg_write   <= id_ex_reg_write;
            r_mem_read    <= id_ex_mem_read;
            r_mem_write   <= id_ex_mem_write;
            r_beq         <= id_ex_beq;
            r_alu_result  <= w_alu;
            r_mux2_result <= w_fwd_b;
            r_flag_beq    <= (w_fwd_a == w_fwd_b);
            r_reg_rd      <= id_ex_reg_rd;
        end
    end

    assign mem_to_reg_out      = r_mem_to_reg;
    assign reg_write_out       = r_reg_write;
    assign mem_read_out        = r_mem_read;
    assign mem_write_out       = r_mem_write;
    assign beq_instruction_out = r_beq;
    assign alu_result_out      = r_alu_result;
    assign mux2_result_out     = r_mux2_result;
    assign flag_beq_out        = r_flag_beq;
    assign reg_rd_out          = r_reg_rd;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline, directly upstream of the MEM stage.
- Takes ID/EX operands and controls, resolves forwarding, and computes the ALU result and the beq equality flag.
- Runs a multi-cycle shift-add multiplier for MUL.
- Registers everything into the EX/MEM pipeline register, whose outputs drive the MEM stage inputs one-to-one.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal XLEN.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_ex_mem_to_reg, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_beq  in  1 each  control bits from ID/EX
- id_ex_alu_ctrl  in  4  ALU operation
- id_ex_alu_src  in  1  1 = operand B is the immediate
- id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  in  XLEN  register and immediate values
- id_ex_reg_rd  in  5  destination register
- forward_a, forward_b  in  2  forwarding selects: 00 = ID/EX value, 10 = alu_ex_mem, 01 = wb_data
- alu_ex_mem  in  XLEN  EX/MEM ALU result fed back from MEM
- wb_data  in  XLEN  MEM/WB write-back value
- flush  in  1  squash the instruction in EX
- stall_out  out  1  hold IF/ID and ID/EX
- mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out  out  1 each  EX/MEM controls
- alu_result_out  out  XLEN  EX/MEM ALU result
- mux2_result_out  out  XLEN  forwarded rs2 value (store data)
- flag_beq_out  out  1  operands equal
- reg_rd_out  out  5  EX/MEM destination register

Behaviour:
- Reset: while reset=0 at a rising edge, all EX/MEM outputs become 0, the FSM goes to IDLE, and the counter and multiplier registers clear. stall_out=0 under reset.
- Operand selection (combinational):
  - fwdA is selected from rs1 by forward_a; fwdB is selected from rs2 by forward_b. Select 11 behaves as 00.
  - opB = id_ex_alu_src ? imm : fwdB.
  - mux2_result = fwdB, never the immediate.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed, result 0 or 1).
  - 0110 SLL and 0111 SRL, shift amount opB[4:0].
  - 1000 MUL: low XLEN bits of the unsigned product.
  - Undefined codes produce 0.
  - Arithmetic wraps modulo 2^XLEN.
- flag_beq = (fwdA == fwdB), computed for every instruction. MEM uses it only when beq_instruction is set.
- Latency: non-MUL instructions take 1 cycle; EX/MEM captures on the next rising edge.
- FSM states: IDLE, MUL, DONE.
  - IDLE with alu_ctrl=1000 and flush=0: latch fwdA and opB into the multiplier, clear the product and counter, go to MUL. stall_out=1 combinationally in this cycle. EX/MEM captures a bubble (all controls 0, data 0).
  - MUL: each cycle, if the multiplier LSB is set, add the multiplicand to the product; shift the multiplicand left and the multiplier right; counter+1. stall_out=1 and EX/MEM takes a bubble. After the MUL_CYCLES-th iteration, go to DONE.
  - DONE: stall_out=0. EX/MEM captures the product together with the held ID/EX controls, then the FSM returns to IDLE. The held MUL opcode must not re-trigger the multiplier in DONE.
  - Net effect: the MUL result appears in EX/MEM at the 34th rising edge after MUL first presents in EX.
- Forwarding inputs are ignored after the operand latch; the upstream stall guarantees ID/EX is stable.
- Flush (has priority over everything except reset): at the next edge EX/MEM captures a bubble. In any FSM state it forces IDLE and aborts the multiply, and stall_out drops at that edge.
- Bubble: mem_write, reg_write, mem_read, beq and mem_to_reg are all 0, so MEM sees pcSrc=0 and performs no write.
- reg_rd 0 passes through unchanged; register-file suppression is not done here.

Decomposition:
- Shared package (pipeline_pkg):
  - ALU_ADD..ALU_MUL codes.
  - FWD_IDEX/FWD_EXMEM/FWD_WB selects.
  - FSM state encoding.
  - XLEN.
- One sub-module, seq_multiplier: start, operands, busy, done, product, holding the shift-add datapath and counter. ex_stage owns the forwarding muxes, ALU, stall logic and EX/MEM register.

Test Plan:
- Reset: drive reset=0 for 2 cycles with nonzero inputs -> every output is 0 and stall_out=0.
- ADD/SUB with forwarding:
  - rs1=5, forward_a=10, alu_ex_mem=100, imm=7, alu_src=1, ADD -> alu_result_out=107 one edge later.
  - SUB of rs1=3, rs2=5 -> 0xFFFFFFFE.
- Branch: beq=1, rs1=rs2=42 -> flag_beq_out=1 and beq_instruction_out=1.
  - With forward_b=01 and wb_data=43 -> flag_beq_out=0.
- Store data: mem_write=1, alu_src=1, imm=8, rs2=12345 -> alu_result_out=8, mux2_result_out=12345, mem_write_out=1.
- MUL: 12345 × 6789.
  - stall_out is high for 33 cycles and EX/MEM holds bubbles.
  - alu_result_out=83810205 at the 34th edge.
  - 0xFFFFFFFF × 2 -> 0xFFFFFFFE.
- Flush during MUL: assert flush at busy cycle 10 -> bubble captured, FSM is IDLE, stall_out=0 next cycle, and no product is ever written.
